clock_switch_ctrl: RTL and testbench

Single-clock sequencer that drives the 2-bit clk_sel input of the glitch-free clock switch. It is the initiator side of the select interface and accepts source-change requests over a valid/ready handshake. For each accepted request it validates the source, drives clk_sel, holds off for a programmable settle window, then reports completion. Software and FSMs request a clock source here instead of toggling clk_sel directly.

---
 rtl/clock_switch_ctrl.sv | 142 ++++++++++++++
 tb/tb_clock_switch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_ctrl.sv
// Drives clk_sel of the glitch-free clock switch from valid/ready requests, then holds off a settle window.
// Build option CLK_SW_DWELL_EN adds a post-switch DWELL hold-off of MIN_DWELL cycles before the next accept.
//
// state  | meaning
// IDLE   | ready for a request; invalid and same-source requests are answered here
// SWITCH | clk_sel updated, counting down the settle window
// DWELL  | (CLK_SW_DWELL_EN only) minimum dwell after a completed switch
module clock_switch_ctrl #(
    parameter int NUM_SRC    = 3,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8,
    parameter int RST_SEL    = 0
`ifdef CLK_SW_DWELL_EN
    ,
    parameter int MIN_DWELL  = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic [1:0] clk_sel,
    output logic [1:0] cur_sel,
    output logic       sw_busy,
    output logic       done,
    output logic       err_invalid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1
`ifdef CLK_SW_DWELL_EN
        ,
        DWELL  = 2'd2
`endif
    } state_t;

    localparam logic [2:0]       NSRC_W    = 3'(NUM_SRC);
    localparam logic [1:0]       RST_SEL_W = 2'(RST_SEL);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef CLK_SW_DWELL_EN
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(MIN_DWELL - 1);
`endif

    state_t           state_q, state_d;
    logic [1:0]       clk_sel_q, clk_sel_d;
    logic [1:0]       cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             sel_legal;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign sel_legal = ({1'b0, req_sel} < NSRC_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_sel_q <= RST_SEL_W;
            cur_sel_q <= RST_SEL_W;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_sel_q <= clk_sel_d;
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_sel_d = clk_sel_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sel_legal) begin
                        err_d = 1'b1;
                    end else if (req_sel == cur_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        clk_sel_d = req_sel;
                        cnt_d     = SETTLE_LD;
                        busy_d    = 1'b1;
                        state_d   = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    // settle window expired: commit the source and report
                    cur_sel_d = clk_sel_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
`ifdef CLK_SW_DWELL_EN
                    cnt_d     = DWELL_LD;
                    state_d   = DWELL;
`else
                    state_d   = IDLE;
`endif
                end
            end
`ifdef CLK_SW_DWELL_EN
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign clk_sel     = clk_sel_q;
    assign cur_sel     = cur_sel_q;
    assign sw_busy     = busy_q;
    assign done        = done_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Scoreboard bench for clock_switch_ctrl: driver predicts each response from a request-level model,
// monitor pops predictions whenever done/err_invalid pulses. Honours CLK_SW_DWELL_EN when defined.
module tb_clock_switch_ctrl;

    localparam int SETTLE = 16;
    localparam int NSRC   = 3;
`ifdef CLK_SW_DWELL_EN
    localparam int DWELL  = 32;
`else
    localparam int DWELL  = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_ready;
    logic [1:0] clk_sel;
    logic [1:0] cur_sel;
    logic       sw_busy;
    logic       done;
    logic       err_invalid;

    clock_switch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .clk_sel     (clk_sel),
        .cur_sel     (cur_sel),
        .sw_busy     (sw_busy),
        .done        (done),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        int         due;
        logic [1:0] cur;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    want;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];

    int vectors = 0;
    int miscompares = 0;

    // request-level reference model
    logic [1:0] m_cur = 2'd0;
    logic [1:0] m_clk = 2'd0;
    int busy_from = 0;
    int busy_to = 0;
    int next_ready = 0;
    int last_acc = 0;
    bit mon_en = 1'b0;

    task automatic compare(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk_t c;
        exp_t e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.got, c.want);
        end
        if (mon_en) begin
            compare("clk_sel", int'(clk_sel), int'(m_clk));
            compare("sw_busy", int'(sw_busy), int'(cyc >= busy_from && cyc < busy_to));
            compare("done_err_overlap", int'(done & err_invalid), 0);
            if (done || err_invalid) begin
                compare("pulse_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    compare("pulse_is_err", int'(err_invalid), int'(e.is_err));
                    compare("pulse_cycle", cyc, e.due);
                    compare("cur_sel_at_pulse", int'(cur_sel), int'(e.cur));
                end
            end
        end
    end

    task automatic push_chk(input string n, input int g, input int w);
        chk_t c;
        c.name = n;
        c.got  = g;
        c.want = w;
        chk_q.push_back(c);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
    task automatic issue(input logic [1:0] sel);
        int   exp_acc;
        int   acc;
        int   waited;
        exp_t e;
        waited    = 0;
        req_sel   = sel;
        req_valid = 1'b1;
        exp_acc   = (cyc + 1 > next_ready) ? cyc + 1 : next_ready;
        while (!req_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            push_chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        push_chk("accept_cycle", acc, exp_acc);
        @(posedge clk);
        #1;
        last_acc = acc;
        if (int'(sel) >= NSRC) begin
            e.is_err = 1'b1; e.due = acc; e.cur = m_cur;
            next_ready = acc + 1;
        end else if (sel == m_cur) begin
            e.is_err = 1'b0; e.due = acc; e.cur = m_cur;
            next_ready = acc + 1;
        end else begin
            m_clk = sel;
            m_cur = sel;
            busy_from = acc;
            busy_to = acc + SETTLE;
            e.is_err = 1'b0; e.due = acc + SETTLE; e.cur = sel;
            next_ready = acc + SETTLE + 1 + DWELL;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        int budget;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        push_chk("rst_clk_sel", int'(clk_sel), 0);
        push_chk("rst_cur_sel", int'(cur_sel), 0);
        push_chk("rst_req_ready", int'(req_ready), 1);
        push_chk("rst_sw_busy", int'(sw_busy), 0);
        push_chk("rst_done", int'(done), 0);
        push_chk("rst_err_invalid", int'(err_invalid), 0);
        mon_en = 1'b1;

        // normal switch, same source, invalid
        issue(2'd1);
        issue(2'd1);
        issue(2'd3);
        idle(3);

        // reset in the middle of a 0->2 switch, when the settle count is at 5
        issue(2'd0);
        issue(2'd2);
        budget = 0;
        while (cyc != last_acc + 10 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        #2;
        req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        m_clk = 2'd0;
        m_cur = 2'd0;
        busy_to = 0;
        next_ready = 0;
        #1;
        push_chk("mid_switch_rst_clk_sel", int'(clk_sel), 0);
        push_chk("mid_switch_rst_busy", int'(sw_busy), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue(2'd2);

        // back-to-back 0->2->1 with req_valid held high
        issue(2'd0);
        issue(2'd2);
        issue(2'd1);

        // randomized requests with random gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            issue(2'($urandom_range(0, 3)));
        end
        req_valid = 1'b0;

        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        push_chk("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
